// File: rtl/cpu_pkg.sv
// Shared fetch-unit types and widths.
package cpu_pkg;

    localparam int unsigned DataW   = 8;
    localparam int unsigned AddrW   = 8;
    localparam int unsigned OpcodeW = 4;

    typedef enum logic [1:0] {
        StFetch1,
        StFetch2,
        StValid,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch unit: reads ir1/ir2 from program memory, then holds them
// for the decoder until it requests the next instruction, branches, or halts.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [AddrW-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [AddrW-1:0]   mem_addr,
    input  logic               mem_ack,
    input  logic [DataW-1:0]   mem_rdata,
    input  logic               fetch_next,
    input  logic               pc_load,
    input  logic [AddrW-1:0]   pc_target,
    input  logic               halt,
    output logic               ir_valid,
    output logic [DataW-1:0]   ir1,
    output logic [DataW-1:0]   ir2,
    output logic [OpcodeW-1:0] opcode,
    output logic [AddrW-1:0]   pc,
    output logic               halted
);

    fetch_state_e     state_q, state_d;
    logic [AddrW-1:0] pc_q, pc_d;
    logic [DataW-1:0] ir1_q, ir1_d;
    logic [DataW-1:0] ir2_q, ir2_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch1;
            pc_q    <= RESET_PC;
            ir1_q   <= '0;
            ir2_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir1_q   <= ir1_d;
            ir2_q   <= ir2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir1_d    = ir1_q;
        ir2_d    = ir2_q;
        mem_req  = 1'b0;
        ir_valid = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            StFetch1: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir1_d   = mem_rdata;
                    pc_d    = pc_q + AddrW'(1);
                    state_d = StFetch2;
                end
            end
            StFetch2: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir2_d   = mem_rdata;
                    pc_d    = pc_q + AddrW'(1);
                    state_d = StValid;
                end
            end
            StValid: begin
                ir_valid = 1'b1;
                // Halt freezes pc and beats any concurrent branch or fetch request.
                if (halt) begin
                    state_d = StHalted;
                end else begin
                    if (pc_load) begin
                        pc_d = pc_target;
                    end
                    if (fetch_next) begin
                        state_d = StFetch1;
                    end
                end
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StFetch1;
            end
        endcase
    end

    assign mem_addr = mem_req ? pc_q : '0;
    assign opcode   = ir1_q[DataW-1 -: OpcodeW];
    assign pc       = pc_q;
    assign ir1      = ir1_q;
    assign ir2      = ir2_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait, wait states, branch, wrap, halt, reset.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ack;
    logic       fetch_next;
    logic       pc_load;
    logic [7:0] pc_target;
    logic       halt;

    logic       mem_req, mem_req2;
    logic [7:0] mem_addr, mem_addr2;
    logic [7:0] mem_rdata, mem_rdata2;
    logic       ir_valid, ir_valid2;
    logic [7:0] ir1, ir2, ir1_2, ir2_2;
    logic [3:0] opcode, opcode2;
    logic [7:0] pc, pc2;
    logic       halted, halted2;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata2 = mem[mem_addr2];

    instr_fetch #(.RESET_PC(8'h00)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fetch_next (fetch_next),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .halt       (halt),
        .ir_valid   (ir_valid),
        .ir1        (ir1),
        .ir2        (ir2),
        .opcode     (opcode),
        .pc         (pc),
        .halted     (halted)
    );

    instr_fetch #(.RESET_PC(8'hFF)) u_dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req2),
        .mem_addr   (mem_addr2),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata2),
        .fetch_next (fetch_next),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .halt       (halt),
        .ir_valid   (ir_valid2),
        .ir1        (ir1_2),
        .ir2        (ir2_2),
        .opcode     (opcode2),
        .pc         (pc2),
        .halted     (halted2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
        mem[8'h00] = 8'h4A;
        mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h21;
        mem[8'h40] = 8'h5B;
        mem[8'h41] = 8'h77;
        mem[8'hFF] = 8'hC3;

        reset      = 1'b0;
        mem_ack    = 1'b0;
        fetch_next = 1'b0;
        pc_load    = 1'b0;
        pc_target  = 8'h00;
        halt       = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_pc_wrap", pc2, 8'hFF);
        chk("rst_ir1", ir1, 8'h00);
        chk("rst_ir2", ir2, 8'h00);
        chk("rst_ir_valid", {7'd0, ir_valid}, 8'h00);
        chk("rst_halted", {7'd0, halted}, 8'h00);

        // Zero-wait fetch of 0x4A 0x12; wrap instance fetches 0xFF then 0x00
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk("a_req", {7'd0, mem_req}, 8'h01);
        chk("a_addr0", mem_addr, 8'h00);
        chk("a_addr0_wrap", mem_addr2, 8'hFF);
        step();
        chk("a_ir1", ir1, 8'h4A);
        chk("a_pc1", pc, 8'h01);
        chk("a_addr1", mem_addr, 8'h01);
        chk("a_valid_early", {7'd0, ir_valid}, 8'h00);
        chk("a_pc1_wrap", pc2, 8'h00);
        chk("a_addr1_wrap", mem_addr2, 8'h00);
        step();
        chk("a_valid", {7'd0, ir_valid}, 8'h01);
        chk("a_ir1_v", ir1, 8'h4A);
        chk("a_ir2_v", ir2, 8'h12);
        chk("a_opcode", {4'd0, opcode}, 8'h04);
        chk("a_pc2", pc, 8'h02);
        chk("a_req_off", {7'd0, mem_req}, 8'h00);
        chk("a_addr_off", mem_addr, 8'h00);
        chk("a_ir1_wrap", ir1_2, 8'hC3);
        chk("a_ir2_wrap", ir2_2, 8'h4A);
        chk("a_pc_wrap", pc2, 8'h01);

        // Ack in VALID is ignored
        step();
        chk("b_ack_ign_valid", {7'd0, ir_valid}, 8'h01);
        chk("b_ack_ign_ir1", ir1, 8'h4A);
        chk("b_ack_ign_pc", pc, 8'h02);

        // Branch without fetch stays in VALID
        mem_ack   = 1'b0;
        pc_load   = 1'b1;
        pc_target = 8'h80;
        step();
        chk("b_load_pc", pc, 8'h80);
        chk("b_load_valid", {7'd0, ir_valid}, 8'h01);

        // Branch with fetch: target wins, then wait-stated fetch from 0x40/0x41
        fetch_next = 1'b1;
        pc_target  = 8'h40;
        step();
        fetch_next = 1'b0;
        pc_load    = 1'b0;
        chk("b_br_valid", {7'd0, ir_valid}, 8'h00);
        chk("b_br_req", {7'd0, mem_req}, 8'h01);
        chk("b_br_addr", mem_addr, 8'h40);
        step();
        chk("b_wait_addr", mem_addr, 8'h40);
        chk("b_wait_req", {7'd0, mem_req}, 8'h01);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("b_addr41", mem_addr, 8'h41);
        chk("b_ir1", ir1, 8'h5B);
        step();
        chk("b_wait_addr41", mem_addr, 8'h41);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("b_valid", {7'd0, ir_valid}, 8'h01);
        chk("b_ir2", ir2, 8'h77);
        chk("b_pc", pc, 8'h42);
        chk("b_opcode", {4'd0, opcode}, 8'h05);

        // Halt beats fetch_next and pc_load
        halt       = 1'b1;
        fetch_next = 1'b1;
        pc_load    = 1'b1;
        pc_target  = 8'h99;
        step();
        halt = 1'b0;
        chk("c_halted", {7'd0, halted}, 8'h01);
        chk("c_valid", {7'd0, ir_valid}, 8'h00);
        chk("c_req", {7'd0, mem_req}, 8'h00);
        chk("c_addr", mem_addr, 8'h00);
        chk("c_pc", pc, 8'h42);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("c_stay_halted", {7'd0, halted}, 8'h01);
        chk("c_stay_req", {7'd0, mem_req}, 8'h00);
        chk("c_stay_pc", pc, 8'h42);

        // Reset out of HALTED, then two wait states per byte
        fetch_next = 1'b0;
        pc_load    = 1'b0;
        mem_ack    = 1'b0;
        reset      = 1'b0;
        #1;
        chk("d_rst_pc", pc, 8'h00);
        chk("d_rst_halted", {7'd0, halted}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_ack = (i % 3 == 2);
            step();
            chk("d_ws_valid", {7'd0, ir_valid}, (i == 5) ? 8'h01 : 8'h00);
            chk("d_ws_req", {7'd0, mem_req}, (i < 5) ? 8'h01 : 8'h00);
            chk("d_ws_addr", mem_addr, (i < 2) ? 8'h00 : ((i < 5) ? 8'h01 : 8'h00));
        end
        chk("d_ir1", ir1, 8'h4A);
        chk("d_ir2", ir2, 8'h12);
        chk("d_pc", pc, 8'h02);

        // Reset mid-FETCH2 discards the partial instruction
        mem_ack    = 1'b0;
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
        mem_ack    = 1'b1;
        step();
        chk("e_ir1_partial", ir1, 8'h21);
        chk("e_pc_partial", pc, 8'h03);
        mem_ack = 1'b0;
        reset   = 1'b0;
        #1;
        chk("e_rst_pc", pc, 8'h00);
        chk("e_rst_ir1", ir1, 8'h00);
        chk("e_rst_ir2", ir2, 8'h00);
        chk("e_rst_valid", {7'd0, ir_valid}, 8'h00);
        @(negedge clk);
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk("e_restart_addr", mem_addr, 8'h00);
        @(negedge clk);
        step();
        chk("e_valid", {7'd0, ir_valid}, 8'h01);
        chk("e_ir1", ir1, 8'h4A);
        chk("e_ir2", ir2, 8'h12);
        chk("e_pc", pc, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
